// File: rtl/pcie_rx_router_if.sv
// TLP slot types shared by the RX router and its bench,
// plus the multi-slot and single-slot RX AXI-S interfaces.
`timescale 1ns/1ps
package pcie_rx_pkg;
  localparam int FIM_PCIE_TLP_CH = 2;
  localparam int HDR_W = 128;
  localparam int PL_W  = 64;
  localparam int BAR_W = 3;

  // hdr[31:0] is DW0; fmttype lives in hdr[31:24].
  typedef struct packed {
    logic             valid;
    logic             sop;
    logic             eop;
    logic [HDR_W-1:0] hdr;
    logic [PL_W-1:0]  payload;
  } t_slot;

  typedef struct packed {
    logic [BAR_W-1:0] bar;
  } t_tuser;
endpackage

interface ofs_fim_pcie_rxs_axis_if #(
  parameter int NUM_CH = pcie_rx_pkg::FIM_PCIE_TLP_CH
);
  import pcie_rx_pkg::*;
  logic                clk;
  logic                rst_n;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  t_slot  [NUM_CH-1:0] tdata;
  t_tuser [NUM_CH-1:0] tuser;

  modport master (
    output clk, rst_n, tvalid, tlast,
    output tdata, tuser,
    input  tready
  );
  modport slave (
    input  tvalid, tlast, tdata, tuser,
    output tready
  );
endinterface

interface ofs_fim_pcie_rx_axis_if;
  import pcie_rx_pkg::*;
  logic   clk;
  logic   rst_n;
  logic   tvalid;
  logic   tready;
  logic   tlast;
  t_slot  tdata;
  t_tuser tuser;

  modport master (
    output clk, rst_n, tvalid, tlast,
    output tdata, tuser,
    input  tready
  );
  modport slave (
    input  tvalid, tlast, tdata, tuser,
    output tready
  );
endinterface

// File: rtl/pcie_rx_router.sv
// RX TLP demux: MMIO-BAR memory requests go to the single-slot
// MMIO stream, everything else to the multi-slot AFU stream.
`timescale 1ns/1ps
module pcie_rx_router
  import pcie_rx_pkg::*;
#(
  parameter int MMIO_BAR = 0,
  parameter int NUM_CH   = FIM_PCIE_TLP_CH
) (
  input  logic clk,
  input  logic rst_n,
  ofs_fim_pcie_rxs_axis_if.slave  i_pcie_rx_st,
  ofs_fim_pcie_rx_axis_if.master  o_mmio_rx_st,
  ofs_fim_pcie_rxs_axis_if.master o_afu_rx_st
);

  typedef enum logic {
    DST_AFU  = 1'b0,
    DST_MMIO = 1'b1
  } dst_e;

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  t_slot  [NUM_CH-1:0] held_q, held_d;
  t_tuser [NUM_CH-1:0] huser_q, huser_d;
  logic                hlast_q, hlast_d;
  logic   [NUM_CH-1:0] pend_q, pend_d;
  logic   [NUM_CH-1:0] mmio_q, mmio_d;
  dst_e                cur_dst_q, cur_dst_d;

  logic   [NUM_CH-1:0] afu_pend;
  logic   [NUM_CH-1:0] mmio_pend;
  logic   [NUM_CH-1:0] mmio_oh;
  logic   [NUM_CH-1:0] clr;
  logic   [SW-1:0]     mmio_sel;
  t_slot  [NUM_CH-1:0] afu_data;
  logic                held_valid;
  logic                beat_done;
  logic                accept;
  logic                afu_fire;
  logic                mmio_fire;

  function automatic logic is_mmio(
    input t_slot  s,
    input t_tuser u
  );
    return (s.hdr[28:24] == 5'b00000) &&
           (u.bar == BAR_W'(MMIO_BAR));
  endfunction

  assign held_valid = |pend_q;
  assign afu_pend   = pend_q & ~mmio_q;
  assign mmio_pend  = pend_q & mmio_q;

  // Select the lowest-index pending MMIO slot.
  always_comb begin
    mmio_sel = '0;
    mmio_oh  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mmio_pend[i]) begin
        mmio_sel   = SW'(i);
        mmio_oh    = '0;
        mmio_oh[i] = 1'b1;
      end
    end
  end

  // AFU beat keeps slot positions; non-AFU slots blanked.
  always_comb begin
    afu_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (afu_pend[i]) afu_data[i] = held_q[i];
    end
  end

  assign afu_fire  = o_afu_rx_st.tvalid
                   & o_afu_rx_st.tready;
  assign mmio_fire = o_mmio_rx_st.tvalid
                   & o_mmio_rx_st.tready;

  assign clr = (afu_fire  ? afu_pend : '0)
             | (mmio_fire ? mmio_oh  : '0);

  assign beat_done = ((pend_q & ~clr) == '0);
  assign accept    = i_pcie_rx_st.tvalid
                   & i_pcie_rx_st.tready;

  assign i_pcie_rx_st.tready =
    rst_n & (~held_valid | beat_done);

  assign o_afu_rx_st.clk    = clk;
  assign o_afu_rx_st.rst_n  = rst_n;
  assign o_afu_rx_st.tvalid = |afu_pend;
  assign o_afu_rx_st.tdata  = afu_data;
  assign o_afu_rx_st.tuser  = huser_q;
  assign o_afu_rx_st.tlast  = hlast_q;

  assign o_mmio_rx_st.clk    = clk;
  assign o_mmio_rx_st.rst_n  = rst_n;
  assign o_mmio_rx_st.tvalid = |mmio_pend;
  assign o_mmio_rx_st.tdata  =
    (|mmio_pend) ? held_q[mmio_sel] : '0;
  assign o_mmio_rx_st.tuser  =
    (|mmio_pend) ? huser_q[mmio_sel] : '0;
  assign o_mmio_rx_st.tlast  =
    (|mmio_pend) & held_q[mmio_sel].eop;

  // Retire dispatched slots, or load and route a new beat.
  always_comb begin
    held_d    = held_q;
    huser_d   = huser_q;
    hlast_d   = hlast_q;
    mmio_d    = mmio_q;
    cur_dst_d = cur_dst_q;
    pend_d    = pend_q & ~clr;
    if (accept) begin
      held_d  = i_pcie_rx_st.tdata;
      huser_d = i_pcie_rx_st.tuser;
      hlast_d = i_pcie_rx_st.tlast;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_d[i] = i_pcie_rx_st.tdata[i].valid;
        if (i_pcie_rx_st.tdata[i].valid &&
            i_pcie_rx_st.tdata[i].sop) begin
          cur_dst_d =
            is_mmio(i_pcie_rx_st.tdata[i],
                    i_pcie_rx_st.tuser[i])
            ? DST_MMIO : DST_AFU;
        end
        mmio_d[i] = (cur_dst_d == DST_MMIO);
      end
    end
  end

  // Holding register and route state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q    <= '0;
      huser_q   <= '0;
      hlast_q   <= 1'b0;
      pend_q    <= '0;
      mmio_q    <= '0;
      cur_dst_q <= DST_AFU;
    end else begin
      held_q    <= held_d;
      huser_q   <= huser_d;
      hlast_q   <= hlast_d;
      pend_q    <= pend_d;
      mmio_q    <= mmio_d;
      cur_dst_q <= cur_dst_d;
    end
  end

endmodule

// File: tb/tb_pcie_rx_router.sv
// Bench for pcie_rx_router: directed timing cases plus random
// traffic scored against a per-TLP routing model.
`timescale 1ns/1ps
module tb_pcie_rx_router;
  import pcie_rx_pkg::*;
  localparam int NCH = FIM_PCIE_TLP_CH;

  localparam logic [7:0] FT_MRD  = 8'h00;
  localparam logic [7:0] FT_MWR  = 8'h40;
  localparam logic [7:0] FT_CPLD = 8'h4A;
  localparam logic [7:0] FT_MSG  = 8'h30;

  typedef struct packed {
    t_slot  s;
    t_tuser u;
  } mm_exp_t;

  typedef struct packed {
    t_slot  [NCH-1:0] d;
    t_tuser [NCH-1:0] u;
    logic             last;
  } afu_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofs_fim_pcie_rxs_axis_if #(.NUM_CH(NCH)) rx_if();
  ofs_fim_pcie_rx_axis_if                  mmio_if();
  ofs_fim_pcie_rxs_axis_if #(.NUM_CH(NCH)) afu_if();

  pcie_rx_router #(
    .MMIO_BAR(0),
    .NUM_CH(NCH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_pcie_rx_st(rx_if),
    .o_mmio_rx_st(mmio_if),
    .o_afu_rx_st(afu_if)
  );

  assign rx_if.clk   = clk;
  assign rx_if.rst_n = rst_n;

  int  vecs = 0;
  int  errs = 0;
  int  cyc  = 0;
  bit  rnd_bp = 1'b0;
  bit  t4_on  = 1'b0;
  logic mm_rdy = 1'b1, af_rdy = 1'b1;
  logic rnd_m = 1'b1, rnd_a = 1'b1;

  assign mmio_if.tready = rnd_bp ? rnd_m : mm_rdy;
  assign afu_if.tready  = rnd_bp ? rnd_a : af_rdy;

  mm_exp_t  mq[$];
  afu_exp_t aq[$];
  bit       m_mmio = 1'b0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic t_slot mk(input logic sop,
                               input logic eop,
                               input logic [7:0] ft);
    t_slot s;
    s.valid = 1'b1;
    s.sop = sop;
    s.eop = eop;
    s.hdr = {$urandom, $urandom, $urandom, $urandom};
    if (sop) s.hdr[31:24] = ft;
    s.payload = {$urandom, $urandom};
    return s;
  endfunction

  // Memory request (type 0) to BAR0 is MMIO, all else AFU.
  function automatic bit goes_mmio(input t_slot s,
                                   input t_tuser u);
    logic [7:0] ft;
    ft = s.hdr[31:24];
    return (ft[4:0] == 5'd0) && (u.bar == 3'd0);
  endfunction

  task automatic model_beat(input t_slot  [NCH-1:0] d,
                            input t_tuser [NCH-1:0] u,
                            input logic last);
    afu_exp_t b;
    bit any;
    b = '0;
    any = 1'b0;
    b.u = u;
    b.last = last;
    for (int i = 0; i < NCH; i++) begin
      if (d[i].valid) begin
        if (d[i].sop) m_mmio = goes_mmio(d[i], u[i]);
        if (m_mmio) mq.push_back({d[i], u[i]});
        else begin
          b.d[i] = d[i];
          any = 1'b1;
        end
      end
    end
    if (any) aq.push_back(b);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_m = ($urandom_range(0, 3) != 0);
    rnd_a = ($urandom_range(0, 3) != 0);
  end

  mm_exp_t  me;
  afu_exp_t ae;
  afu_exp_t af_prev;
  logic [$bits(t_slot)+BAR_W:0] mm_prev;
  bit mm_hold = 1'b0, af_hold = 1'b0;

  // Scoreboard: outputs, hold-while-stalled, input accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      aq.delete();
      m_mmio  = 1'b0;
      mm_hold = 1'b0;
      af_hold = 1'b0;
    end else begin
      if (t4_on) chk("t4_mmio_idle", mmio_if.tvalid, 0);
      if (mm_hold)
        chk("mmio_hold",
            {mmio_if.tvalid, mmio_if.tdata,
             mmio_if.tuser, mmio_if.tlast},
            {1'b1, mm_prev});
      if (af_hold) begin
        chk("afu_hold_v", afu_if.tvalid, 1);
        for (int i = 0; i < NCH; i++)
          chk("afu_hold_slot", afu_if.tdata[i],
              af_prev.d[i]);
        chk("afu_hold_ul",
            {afu_if.tuser, afu_if.tlast},
            {af_prev.u, af_prev.last});
      end
      mm_hold = mmio_if.tvalid && !mmio_if.tready;
      mm_prev = {mmio_if.tdata, mmio_if.tuser,
                 mmio_if.tlast};
      af_hold = afu_if.tvalid && !afu_if.tready;
      af_prev = {afu_if.tdata, afu_if.tuser,
                 afu_if.tlast};
      if (mmio_if.tvalid && mmio_if.tready) begin
        if (mq.size() == 0) chk("mmio_extra", 1, 0);
        else begin
          me = mq.pop_front();
          chk("mmio_data", mmio_if.tdata, me.s);
          chk("mmio_user", mmio_if.tuser, me.u);
          chk("mmio_last", mmio_if.tlast, me.s.eop);
        end
      end
      if (afu_if.tvalid && afu_if.tready) begin
        if (aq.size() == 0) chk("afu_extra", 1, 0);
        else begin
          ae = aq.pop_front();
          for (int i = 0; i < NCH; i++)
            chk("afu_slot", afu_if.tdata[i], ae.d[i]);
          chk("afu_user", afu_if.tuser, ae.u);
          chk("afu_last", afu_if.tlast, ae.last);
        end
      end
      if (rx_if.tvalid && rx_if.tready)
        model_beat(rx_if.tdata, rx_if.tuser, rx_if.tlast);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a beat until accepted; returns #1 after the edge.
  task automatic send(input t_slot  [NCH-1:0] d,
                      input t_tuser [NCH-1:0] u,
                      input logic last);
    bit ok;
    ok = 1'b0;
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = d;
    rx_if.tuser  = u;
    rx_if.tlast  = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = rx_if.tready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    rx_if.tuser  = '0;
    rx_if.tlast  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  t_slot  [NCH-1:0] d;
  t_tuser [NCH-1:0] u;
  int c0, rem, kind;
  logic [7:0] ft;

  initial begin
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    rx_if.tuser  = '0;
    rx_if.tlast  = 1'b0;
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    chk("rst_rdy", rx_if.tready, 0);
    chk("rst_mvld", mmio_if.tvalid, 0);
    chk("rst_avld", afu_if.tvalid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", rx_if.tready, 1);
    @(posedge clk);
    #1;

    // 1: single MMIO write
    d = '0; u = '0;
    d[0] = mk(1, 1, FT_MWR);
    send(d, u, 1);
    @(negedge clk);
    chk("t1_mvld", mmio_if.tvalid, 1);
    chk("t1_mlast", mmio_if.tlast, 1);
    chk("t1_avld", afu_if.tvalid, 0);
    chk("t1_rdy", rx_if.tready, 1);
    idle(2);

    // 2: CplD + MRd BAR0 in one beat
    d = '0; u = '0;
    d[0] = mk(1, 1, FT_CPLD);
    d[1] = mk(1, 1, FT_MRD);
    send(d, u, 1);
    @(negedge clk);
    chk("t2_avld", afu_if.tvalid, 1);
    chk("t2_s1v", afu_if.tdata[1].valid, 0);
    chk("t2_mvld", mmio_if.tvalid, 1);
    chk("t2_rdy", rx_if.tready, 1);
    idle(2);

    // 3: two MMIO reads in one beat
    d = '0; u = '0;
    d[0] = mk(1, 1, FT_MRD);
    d[1] = mk(1, 1, FT_MRD);
    send(d, u, 1);
    @(negedge clk);
    chk("t3_mvld1", mmio_if.tvalid, 1);
    chk("t3_rdy1", rx_if.tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_mvld2", mmio_if.tvalid, 1);
    chk("t3_rdy2", rx_if.tready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_mvld3", mmio_if.tvalid, 0);
    idle(2);

    // 4: 3-beat MWr BAR2 while MMIO is stalled
    mm_rdy = 1'b0;
    t4_on = 1'b1;
    c0 = cyc;
    d = '0; u = '0;
    u[0].bar = 3'd2;
    d[0] = mk(1, 0, FT_MWR);
    d[1] = mk(0, 0, FT_MRD);
    send(d, u, 0);
    d[0] = mk(0, 0, FT_MRD);
    d[1] = mk(0, 0, FT_MRD);
    send(d, u, 0);
    d = '0;
    d[0] = mk(0, 1, FT_MRD);
    send(d, u, 1);
    chk("t4_cycles", cyc - c0, 3);
    @(negedge clk);
    chk("t4_avld", afu_if.tvalid, 1);
    idle(2);
    t4_on = 1'b0;
    mm_rdy = 1'b1;
    idle(2);

    // 5: mixed beat, AFU stalled 4 cycles
    af_rdy = 1'b0;
    d = '0; u = '0;
    d[0] = mk(1, 1, FT_CPLD);
    d[1] = mk(1, 1, FT_MWR);
    send(d, u, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t5_mvld", mmio_if.tvalid, (j == 0));
      chk("t5_avld", afu_if.tvalid, 1);
      chk("t5_rdy", rx_if.tready, 0);
      @(posedge clk);
      #1;
    end
    af_rdy = 1'b1;
    @(negedge clk);
    chk("t5_avld_hs", afu_if.tvalid, 1);
    chk("t5_rdy_hs", rx_if.tready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_avld_end", afu_if.tvalid, 0);
    idle(2);

    // 6: reset during beat 2 of a 3-beat AFU TLP
    d = '0; u = '0;
    u[0].bar = 3'd2;
    d[0] = mk(1, 0, FT_MWR);
    d[1] = mk(0, 0, FT_MRD);
    send(d, u, 0);
    d[0] = mk(0, 0, FT_MRD);
    d[1] = mk(0, 0, FT_MRD);
    send(d, u, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_avld", afu_if.tvalid, 0);
    chk("t6_mvld", mmio_if.tvalid, 0);
    chk("t6_s0v", afu_if.tdata[0].valid, 0);
    chk("t6_rdy", rx_if.tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rel_rdy", rx_if.tready, 1);
    @(posedge clk); #1;
    d = '0; u = '0;
    d[0] = mk(0, 1, FT_MRD);
    d[0].hdr[31:24] = FT_MWR;
    send(d, u, 1);
    @(negedge clk);
    chk("t6_orph_a", afu_if.tvalid, 1);
    chk("t6_orph_m", mmio_if.tvalid, 0);
    @(posedge clk); #1;
    d = '0; u = '0;
    d[0] = mk(1, 1, FT_MWR);
    send(d, u, 1);
    @(negedge clk);
    chk("t6_mwr_m", mmio_if.tvalid, 1);
    chk("t6_mwr_a", afu_if.tvalid, 0);
    idle(3);

    // Random traffic with random output backpressure
    rnd_bp = 1'b1;
    rem = 0;
    for (int b = 0; b < 1500; b++) begin
      for (int i = 0; i < NCH; i++) begin
        u[i].bar = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 4) == 0) begin
          d[i] = mk(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), FT_MRD);
          d[i].valid = 1'b0;
        end else begin
          if (rem == 0) begin
            kind = $urandom_range(0, 3);
            case (kind)
              0: ft = FT_MRD | 8'($urandom_range(0, 1) << 5);
              1: ft = FT_MWR | 8'($urandom_range(0, 1) << 5);
              2: ft = FT_CPLD;
              default: ft = FT_MSG;
            endcase
            rem = $urandom_range(1, 3);
            d[i] = mk(1, rem == 1, ft);
          end else begin
            d[i] = mk(0, rem == 1, ft);
          end
          rem--;
        end
      end
      if ($urandom_range(0, 3) == 0) idle(1);
      send(d, u, 1'($urandom_range(0, 1)));
    end
    rnd_bp = 1'b0;
    mm_rdy = 1'b1;
    af_rdy = 1'b1;
    idle(30);
    chk("drain_mmio", mq.size(), 0);
    chk("drain_afu", aq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/pcie_rx_router.md
# pcie_rx_router

Receive-side counterpart of the PCIe TX arbiter. It sits between the PCIe RX stream from the hard IP and the two FIM consumers, the FIM MMIO/CSR path and the AFU path. It demultiplexes each TLP by type and BAR, and keeps every TLP contiguous on its destination. A 2-channel input beat is split per slot, and MMIO-bound slots are serialized onto the single-channel MMIO stream.

## Interface
Parameters:
- `MMIO_BAR`, default 0: BAR number whose memory requests go to MMIO.
- `NUM_CH`, default `FIM_PCIE_TLP_CH` (2): number of TLP slots per input beat.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `i_pcie_rx_st`, `ofs_fim_pcie_rxs_axis_if.slave`: upstream RX stream, NUM_CH slots per beat. Each slot carries valid, sop, eop, hdr and payload, plus tuser with the bar field.
- `o_mmio_rx_st`, `ofs_fim_pcie_rx_axis_if.master`: single-slot stream to the FIM MMIO path.
- `o_afu_rx_st`, `ofs_fim_pcie_rxs_axis_if.master`: NUM_CH-slot stream to the AFU.
- `o_mmio_rx_st.clk` = `clk`, `o_mmio_rx_st.rst_n` = `rst_n`; `o_afu_rx_st` is driven the same way.

## Operation
- **Input holding register.** One beat, `held`, with a per-slot pending mask `pend[NUM_CH-1:0]`.
  - `i_pcie_rx_st.tready` = `~held_valid | beat_done`, where `beat_done` means every pending slot is dispatched this cycle.
  - On accept: `held` <= input beat, `pend` <= input slot valids. A beat with tvalid but no valid slot is accepted and discarded.
- **Slot classification**, applied at a slot with sop:
  - Memory request (fmttype[4:0]==5'b00000) with tuser bar == MMIO_BAR: destination MMIO.
  - Everything else (completions, other BARs, messages): destination AFU.
  - Non-sop slots inherit the current route register `cur_dst`, which is updated by every sop slot in slot order (slot 0 first).
  - A continuation slot with no open TLP after reset goes to AFU.
- **AFU dispatch.**
  - All pending AFU slots of the held beat are presented in one AFU beat, in their original slot positions.
  - Non-AFU slots are forced to valid=0, with hdr/payload zeroed.
  - tvalid is high iff at least one such slot is pending; tuser is passed per slot; tlast = input tlast.
  - The AFU slots clear when AFU tvalid & tready.
- **MMIO dispatch.**
  - The lowest-index pending MMIO slot is presented on `tdata`/`tuser`, one slot per cycle; tlast = that slot's eop.
  - It clears on MMIO tvalid & tready. A second MMIO slot in the same beat follows on the next cycle.
- **Independence.**
  - MMIO and AFU dispatch proceed in the same cycle; each side's backpressure never blocks the other side's slots within the held beat.
  - A new beat is not accepted until all slots of the held beat are dispatched.
  - Order within each destination is preserved.
- **Contiguity.** Route state changes only at sop, so a multi-beat TLP goes entirely to one destination.

## Timing
- **Latency.** Input accepted in cycle N; outputs valid in cycle N+1 (combinational from `held`). Throughput is one beat per cycle when each beat has at most one MMIO slot and both outputs are ready.
- **Reset** (`rst_n` low at a `clk` edge):
  - held_valid=0, pend=0, cur_dst=AFU.
  - i_pcie_rx_st.tready=0, o_mmio_rx_st.tvalid=0, o_afu_rx_st.tvalid=0; all output slot valids 0.
  - A reset mid-packet discards the partial TLP with no output beat.
  - tready rises in the first cycle after release.
- **Simultaneous dispatch.** When the last MMIO and last AFU slots dispatch in the same cycle, `beat_done`=1 and a new beat may load in that cycle, with no bubble.
- **Two MMIO slots in one beat.** Input tready is low for exactly one extra cycle (assuming MMIO ready).
- **Stable outputs.** Outputs hold stable while tvalid & ~tready (AXI-S rule). tvalid never drops before the handshake except on reset.

## Test plan
1. **Single MMIO write.** One beat, slot0 = MWr (BAR0, sop/eop), slot1 invalid, both readys high → MMIO tvalid=1 at N+1 with tdata = slot0 and tlast=1; AFU tvalid stays 0; tready stays high.
2. **Mixed beat, one cycle.** Slot0 = CplD, slot1 = MRd BAR0 → in the same cycle the AFU gets tdata[0] = CplD with tdata[1].valid=0, and MMIO gets the MRd; the beat is consumed in one cycle.
3. **Two MMIO reads in one beat.** Slot0 = MRd BAR0, slot1 = MRd BAR0 → MMIO presents slot0 at N+1 and slot1 at N+2; input tready=0 at N+1 only.
4. **AFU progresses while MMIO blocked.** A 3-beat MWr to BAR2, with o_mmio tready held low throughout → the AFU receives 3 beats back-to-back and MMIO tvalid stays 0.
5. **Split backpressure.** Mixed beat (slot0 AFU, slot1 MMIO) with AFU tready low for 4 cycles → MMIO handshakes once at N+1 with no repeat; AFU data is stable for 4 cycles then handshakes once; tready returns high.
6. **Reset mid-packet.** Assert reset during beat 2 of a 3-beat AFU TLP → all tvalids are 0 next cycle. After release, a new BAR0 MWr routes to MMIO correctly and no stale slot appears.
